program_sequencer: RTL and testbench
====================================

PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter WORD_W, default 16, instruction word width.
REQ-002 SHALL have parameter IMEM_DEPTH, default 32, instruction memory depth; the address width is 5.
REQ-003 SHALL have port PCLK  input  1  system clock; all state updates on its rising edge.
REQ-004 SHALL have port RST  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port load_req  input  1  level; request a program load.
REQ-006 SHALL have port prog_valid  input  1  a load word is present.
REQ-007 SHALL have port prog_data  input  WORD_W  the load word.
REQ-008 SHALL have port prog_ready  output  1  the sequencer accepts a load word.
REQ-009 SHALL have ports imem_we  output  1, imem_waddr  output  5, and imem_wdata  output  WORD_W; these form the instruction memory write port.
REQ-010 SHALL have port start  input  1  begin execution.
REQ-011 SHALL have ports step_mode  input  1 and step  input  1  single-step control.
REQ-012 SHALL have ports pc  input  5 and halt_op  input  1  current PC and decoded HALT opcode.
REQ-013 SHALL have port pc_reset  output  1  one-cycle PC clear.
REQ-014 SHALL have ports ir_load  output  1 and exec_en  output  1  fetch and execute strobes.
REQ-015 SHALL have port load_done  output  1  PC advance enable to the program counter block.
REQ-016 SHALL have ports state  output  3 and halted  output  1  status.

Function
REQ-017 SHALL implement the states IDLE, LOAD, READY, FETCH, EXEC, STEP_WAIT and HALT.
REQ-018 SHALL transition IDLE->LOAD when load_req=1; from READY or HALT, load_req=1 SHALL also go to LOAD, with load_req taking priority over start.
REQ-019 SHALL, in LOAD, hold prog_ready=1; each prog_valid&prog_ready cycle SHALL write prog_data to imem_waddr with imem_we=1 in the same cycle, then increment imem_waddr.
REQ-020 SHALL, on the write to address 31, clear imem_waddr to 0 and go LOAD->READY in the next cycle; prog_ready SHALL be 0 outside LOAD.
REQ-021 SHALL, in LOAD, ignore start and step.
REQ-022 SHALL transition READY->FETCH or HALT->FETCH on start=1; the transition cycle SHALL assert pc_reset=1 for exactly one cycle.
REQ-023 SHALL hold FETCH for 1 cycle with ir_load=1, then go to EXEC.
REQ-024 SHALL hold EXEC for 1 cycle with exec_en=1 and load_done=1, so the PC advances or jumps at the end of EXEC.
REQ-025 SHALL, from EXEC, go to HALT when halt_op=1 or pc=31, with load_done=0 in that cycle; otherwise it SHALL go to STEP_WAIT when step_mode=1, else to FETCH.
REQ-026 SHALL treat STEP_WAIT->FETCH on step=1 as a single-cycle pulse; step SHALL be ignored in all other states.
REQ-027 SHALL produce one instruction per 2 cycles in free-run mode.
REQ-028 SHALL hold load_done=0 in every state except EXEC.
REQ-029 SHALL assert halted=1 only in HALT; state SHALL encode IDLE=0, LOAD=1, READY=2, FETCH=3, EXEC=4, STEP_WAIT=5, HALT=6.
REQ-030 SHALL have no combinational path from prog_valid to prog_ready.

Reset
REQ-031 SHALL, when RST=1 at a rising edge, enter IDLE with imem_waddr=0, and every strobe and prog_ready at 0.
REQ-032 SHALL suppress imem_we in the RST cycle when reset occurs mid-LOAD, and SHALL restart a reload at address 0.
REQ-033 SHALL give RST priority over every other input.

Structure
REQ-034 SHALL place the state encoding, LAST_ADDR=31 and the default widths in the shared package seq_pkg.
REQ-035 SHALL implement the load address counter as sub-module load_addr_counter, with inputs clear and inc, output 5-bit addr, and wrap at 31.

Verification
REQ-036 SHALL cover: load 32 words 0x1000..0x101F with prog_valid held high -> 32 imem_we pulses at addr 0..31, then state=READY.
REQ-037 SHALL cover: prog_valid toggled every other cycle during load -> no dropped or duplicated write, and the word count is 32.
REQ-038 SHALL cover: start with pc sweeping 0..31 -> pc_reset pulses once, ir_load/exec_en alternate, and halted=1 after the EXEC at pc=31.
REQ-039 SHALL cover: halt_op=1 at pc=5 -> HALT, with load_done=0 in that EXEC.
REQ-040 SHALL cover: step_mode=1 with 3 step pulses -> exactly 3 EXEC cycles.
REQ-041 SHALL cover: RST asserted after 10 load writes, then reload -> imem_we=0 in the reset cycle, and the first new write goes to addr 0.

Source files
------------

// File: rtl/seq_pkg.sv
// Shared definitions for the program sequencer: state encoding, address width, defaults.
// Latency: n/a (package only).
// Backpressure: n/a.
package seq_pkg;

    localparam int WORD_W_DEF     = 16;
    localparam int IMEM_DEPTH_DEF = 32;
    localparam int ADDR_W         = 5;

    // Highest instruction address; a load ends on it and execution halts on it.
    localparam logic [ADDR_W-1:0] LAST_ADDR = 5'd31;

    // Encoding is visible on the status port, so the values are fixed.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_READY     = 3'd2,
        ST_FETCH     = 3'd3,
        ST_EXEC      = 3'd4,
        ST_STEP_WAIT = 3'd5,
        ST_HALT      = 3'd6
    } seq_state_t;

endpackage

// File: rtl/load_addr_counter.sv
// Instruction memory load address counter, wraps from LAST_ADDR back to 0.
// Latency: address updates one cycle after inc; clear/rst take effect at the next edge.
// Backpressure: none; advances only on inc.
// Ports: clk, rst (sync, active-high), clear (return to 0), inc (advance), addr (current address).
module load_addr_counter
    import seq_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              inc,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] r_addr;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            r_addr <= '0;
        end else if (inc) begin
            r_addr <= (r_addr == LAST_ADDR) ? '0 : r_addr + ADDR_W'(1);
        end
    end

    assign addr = r_addr;

endmodule

// File: rtl/program_sequencer.sv
// Program sequencer: loads instruction memory, then drives fetch/execute strobes (free-run or single-step).
// Latency: one imem write per accepted load word; one instruction per 2 cycles in free-run.
// Backpressure: prog_ready is a pure function of state, high for the whole LOAD state.
// Ports: PCLK/RST; load handshake load_req/prog_valid/prog_data/prog_ready; imem write port
//        imem_we/imem_waddr/imem_wdata; run control start/step_mode/step; PC feedback pc/halt_op;
//        strobes pc_reset/ir_load/exec_en/load_done; status state/halted.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int WORD_W     = WORD_W_DEF,
    parameter int IMEM_DEPTH = IMEM_DEPTH_DEF
) (
    input  logic              PCLK,
    input  logic              RST,
    input  logic              load_req,
    input  logic              prog_valid,
    input  logic [WORD_W-1:0] prog_data,
    output logic              prog_ready,
    output logic              imem_we,
    output logic [ADDR_W-1:0] imem_waddr,
    output logic [WORD_W-1:0] imem_wdata,
    input  logic              start,
    input  logic              step_mode,
    input  logic              step,
    input  logic [ADDR_W-1:0] pc,
    input  logic              halt_op,
    output logic              pc_reset,
    output logic              ir_load,
    output logic              exec_en,
    output logic              load_done,
    output logic [2:0]        state,
    output logic              halted
);

    localparam logic [ADDR_W-1:0] LAST_LOAD_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    seq_state_t        r_state;
    seq_state_t        w_state_nxt;
    logic [ADDR_W-1:0] w_addr;

    load_addr_counter u_addr (
        .clk   (PCLK),
        .rst   (RST),
        .clear (r_state != ST_LOAD),
        .inc   (imem_we),
        .addr  (w_addr)
    );

    always_ff @(posedge PCLK) begin
        if (RST) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        prog_ready  = 1'b0;
        imem_we     = 1'b0;
        pc_reset    = 1'b0;
        ir_load     = 1'b0;
        exec_en     = 1'b0;
        load_done   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (load_req) w_state_nxt = ST_LOAD;
            end
            ST_LOAD: begin
                prog_ready = 1'b1;
                imem_we    = prog_valid;
                if (prog_valid && (w_addr == LAST_LOAD_ADDR)) w_state_nxt = ST_READY;
            end
            ST_READY, ST_HALT: begin
                // A reload request wins over start.
                if (load_req) begin
                    w_state_nxt = ST_LOAD;
                end else if (start) begin
                    w_state_nxt = ST_FETCH;
                    pc_reset    = 1'b1;
                end
            end
            ST_FETCH: begin
                ir_load     = 1'b1;
                w_state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                exec_en = 1'b1;
                // The last instruction must not advance the PC past the end.
                if (halt_op || (pc == LAST_ADDR)) begin
                    w_state_nxt = ST_HALT;
                end else begin
                    load_done   = 1'b1;
                    w_state_nxt = step_mode ? ST_STEP_WAIT : ST_FETCH;
                end
            end
            ST_STEP_WAIT: begin
                if (step) w_state_nxt = ST_FETCH;
            end
            default: w_state_nxt = ST_IDLE;
        endcase

        // Reset overrides everything, including a write already in flight this cycle.
        if (RST) begin
            w_state_nxt = ST_IDLE;
            prog_ready  = 1'b0;
            imem_we     = 1'b0;
            pc_reset    = 1'b0;
            ir_load     = 1'b0;
            exec_en     = 1'b0;
            load_done   = 1'b0;
        end
    end

    assign imem_waddr = w_addr;
    assign imem_wdata = prog_data;
    assign state      = r_state;
    assign halted     = (r_state == ST_HALT);

endmodule

// File: tb/tb_program_sequencer.sv
module tb_program_sequencer;

    logic        PCLK = 1'b0;
    logic        RST = 1'b1;
    logic        load_req = 1'b0;
    logic        prog_valid = 1'b0;
    logic [15:0] prog_data = '0;
    logic        prog_ready;
    logic        imem_we;
    logic [4:0]  imem_waddr;
    logic [15:0] imem_wdata;
    logic        start = 1'b0;
    logic        step_mode = 1'b0;
    logic        step = 1'b0;
    logic [4:0]  pc = '0;
    logic        halt_op = 1'b0;
    logic        pc_reset;
    logic        ir_load;
    logic        exec_en;
    logic        load_done;
    logic [2:0]  state;
    logic        halted;

    program_sequencer #(.WORD_W(16), .IMEM_DEPTH(32)) dut (
        .PCLK(PCLK), .RST(RST), .load_req(load_req), .prog_valid(prog_valid),
        .prog_data(prog_data), .prog_ready(prog_ready), .imem_we(imem_we),
        .imem_waddr(imem_waddr), .imem_wdata(imem_wdata), .start(start),
        .step_mode(step_mode), .step(step), .pc(pc), .halt_op(halt_op),
        .pc_reset(pc_reset), .ir_load(ir_load), .exec_en(exec_en),
        .load_done(load_done), .state(state), .halted(halted)
    );

    always #5 PCLK = ~PCLK;

    // Mode names follow the documented status encoding.
    localparam int M_IDLE = 0, M_LOAD = 1, M_READY = 2, M_FETCH = 3,
                   M_EXEC = 4, M_WAIT = 5, M_HALT = 6;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: current mode, next load slot, loaded image.
    int          m_mode;
    int          m_slot;
    logic [15:0] m_img [32];

    // Observed DUT activity.
    int          n_we = 0, n_exec = 0, n_ir = 0, n_pcr = 0, n_ld = 0;
    int          log_addr [$];
    logic [15:0] log_data [$];
    bit          s_pcr, s_ld;
    bit          rand_jump = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: check outputs mid-cycle, then advance model and PC block after the edge.
    task automatic cyc();
        bit e_rdy, e_we, e_pcr, e_ir, e_ex, e_ld;
        @(negedge PCLK);
        e_rdy = !RST && (m_mode == M_LOAD);
        e_we  = e_rdy && prog_valid;
        e_pcr = !RST && (m_mode == M_READY || m_mode == M_HALT) && start && !load_req;
        e_ir  = !RST && (m_mode == M_FETCH);
        e_ex  = !RST && (m_mode == M_EXEC);
        e_ld  = e_ex && !halt_op && (pc != 5'd31);
        chk("state", state, m_mode);
        chk("halted", halted, m_mode == M_HALT);
        chk("prog_ready", prog_ready, e_rdy);
        chk("imem_we", imem_we, e_we);
        chk("imem_waddr", imem_waddr, m_slot);
        chk("pc_reset", pc_reset, e_pcr);
        chk("ir_load", ir_load, e_ir);
        chk("exec_en", exec_en, e_ex);
        chk("load_done", load_done, e_ld);
        if (e_we) chk("imem_wdata", imem_wdata, prog_data);
        if (imem_we) begin
            n_we++;
            log_addr.push_back(int'(imem_waddr));
            log_data.push_back(imem_wdata);
        end
        n_exec += int'(exec_en);
        n_ir   += int'(ir_load);
        n_pcr  += int'(pc_reset);
        n_ld   += int'(load_done);
        s_pcr = pc_reset;
        s_ld  = load_done;
        @(posedge PCLK);
        #1;
        if (RST) begin
            m_mode = M_IDLE;
            m_slot = 0;
        end else begin
            case (m_mode)
                M_IDLE:  if (load_req) m_mode = M_LOAD;
                M_LOAD:  if (prog_valid) begin
                             m_img[m_slot] = prog_data;
                             m_slot = (m_slot + 1) % 32;
                             if (m_slot == 0) m_mode = M_READY;
                         end
                M_READY, M_HALT: begin
                    if (load_req)   m_mode = M_LOAD;
                    else if (start) m_mode = M_FETCH;
                end
                M_FETCH: m_mode = M_EXEC;
                M_EXEC:  begin
                    if (halt_op || pc == 5'd31) m_mode = M_HALT;
                    else if (step_mode)         m_mode = M_WAIT;
                    else                        m_mode = M_FETCH;
                end
                M_WAIT:  if (step) m_mode = M_FETCH;
                default: m_mode = M_IDLE;
            endcase
        end
        // Program counter block driven by the strobes.
        if (s_pcr)     pc = '0;
        else if (s_ld) pc = (rand_jump && $urandom_range(7) == 0) ? 5'($urandom) : pc + 5'd1;
    endtask

    // Request a load and feed words base+n; optionally stop after stop_after writes.
    task automatic do_load(input logic [15:0] base, input bit toggle, input int stop_after,
                           output int first_idx);
        int  w0;
        bit  done;
        w0 = n_we;
        first_idx = n_we;
        done = 0;
        prog_valid = 0;
        load_req = 1;
        cyc();
        load_req = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            prog_valid = toggle ? (i % 2 == 1) : 1'b1;
            prog_data  = base + 16'(n_we - w0);
            cyc();
            if (m_mode != M_LOAD) done = 1;
            if (stop_after > 0 && (n_we - w0) == stop_after) done = 1;
        end
        prog_valid = 0;
        chk("load_done_in_bound", done, 1);
    endtask

    // Pulse start and run until HALT; halt_op fires when pc equals halt_at (-1 = never).
    task automatic run_to_halt(input int halt_at);
        bit done;
        done = 0;
        halt_op = 0;
        start = 1;
        cyc();
        start = 0;
        for (int i = 0; i < 300 && !done; i++) begin
            halt_op = (halt_at >= 0) && (int'(pc) == halt_at);
            cyc();
            if (m_mode == M_HALT) done = 1;
        end
        halt_op = 0;
        chk("run_halt_in_bound", done, 1);
    endtask

    initial begin
        int fi, e0, i0, p0, l0, w0;
        bit done;

        m_mode = M_IDLE;
        m_slot = 0;
        // First edge with reset brings the DUT out of X before any checking.
        @(posedge PCLK);
        #1;
        repeat (2) cyc();
        chk("reset_state", state, 0);
        chk("reset_waddr", imem_waddr, 0);
        RST = 0;
        cyc();

        // Full-rate load of 0x1000..0x101F.
        do_load(16'h1000, 0, 0, fi);
        chk("load1_count", n_we - fi, 32);
        for (int i = 0; i < 32; i++) begin
            chk("load1_addr", log_addr[fi + i], i);
            chk("load1_data", log_data[fi + i], 16'h1000 + 16'(i));
        end
        chk("load1_ready", state, 2);

        // Free run sweeping pc 0..31.
        e0 = n_exec; i0 = n_ir; p0 = n_pcr;
        run_to_halt(-1);
        chk("sweep_pc_reset", n_pcr - p0, 1);
        chk("sweep_exec", n_exec - e0, 32);
        chk("sweep_fetch", n_ir - i0, 32);
        chk("sweep_halted", halted, 1);

        // halt_op at pc=5, restarted from HALT.
        e0 = n_exec; l0 = n_ld;
        run_to_halt(5);
        chk("halt5_exec", n_exec - e0, 6);
        chk("halt5_load_done", n_ld - l0, 5);
        chk("halt5_pc", pc, 5);

        // Reload from HALT with prog_valid toggling.
        do_load(16'h2000, 1, 0, fi);
        chk("load2_count", n_we - fi, 32);
        for (int i = 0; i < 32; i++) begin
            chk("load2_addr", log_addr[fi + i], i);
            chk("load2_data", log_data[fi + i], 16'h2000 + 16'(i));
        end

        // Single-step: three step pulses give three executions.
        step_mode = 1;
        start = 1;
        cyc();
        start = 0;
        done = 0;
        for (int i = 0; i < 10 && !done; i++) begin
            cyc();
            if (m_mode == M_WAIT) done = 1;
        end
        chk("step_wait_in_bound", done, 1);
        e0 = n_exec;
        for (int k = 0; k < 3; k++) begin
            step = 1;
            cyc();
            step = 0;
            repeat (4) cyc();
        end
        chk("step_exec", n_exec - e0, 3);
        step_mode = 0;

        // Reset in the middle of a load, then reload from address 0.
        RST = 1;
        cyc();
        RST = 0;
        do_load(16'h3000, 0, 10, fi);
        chk("mid_writes", n_we - fi, 10);
        w0 = n_we;
        RST = 1;
        prog_valid = 1;
        cyc();
        chk("rst_cycle_we", n_we - w0, 0);
        RST = 0;
        prog_valid = 0;
        cyc();
        do_load(16'h4000, 0, 0, fi);
        chk("reload_first_addr", log_addr[fi], 0);
        chk("reload_first_data", log_data[fi], 16'h4000);
        chk("reload_count", n_we - fi, 32);

        // Random traffic against the model.
        rand_jump = 1;
        for (int i = 0; i < 4000; i++) begin
            RST        = ($urandom_range(299) == 0);
            load_req   = ($urandom_range(24) == 0);
            start      = ($urandom_range(5) == 0);
            step       = ($urandom_range(2) == 0);
            if ($urandom_range(15) == 0) step_mode = ~step_mode;
            prog_valid = 1'($urandom);
            prog_data  = 16'($urandom);
            halt_op    = ($urandom_range(15) == 0);
            cyc();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
